// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, bounded grant tenure and
// a guaranteed idle bubble between consecutive grants.
module rr_onehot_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     En,
  input  logic [N_REQ-1:0]         Req,
  input  logic                     Done,
  output logic [N_REQ-1:0]         Gnt,
  output logic                     GntValid,
  output logic [$clog2(N_REQ)-1:0] GntIdx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               valid_reg, valid_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   winner;
  logic               release_now;

  // First set request strictly after the pointer, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] res;
    logic             hit;
    int               pos;
    res = ptr;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (!hit && req[pos[IDX_W-1:0]]) begin
        hit = 1'b1;
        res = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

  assign winner      = pick_winner(Req, ptr_reg);
  assign release_now = Done || !Req[idx_reg] || !En || (cnt_reg == HOLD_LIMIT);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      ptr_reg   <= IDX_W'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (En && |Req) begin
          gnt_next   = '0;
          gnt_next[winner] = 1'b1;
          idx_next   = winner;
          ptr_next   = winner;
          cnt_next   = CNT_W'(1);
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Dropping to IDLE forces one all-zero cycle before any new grant.
          gnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg != HOLD_LIMIT) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    valid_next = |gnt_next;
  end

  assign Gnt      = gnt_reg;
  assign GntValid = valid_reg;
  assign GntIdx   = idx_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed scenarios plus random
// traffic compared against a behavioural round-robin model.
module tb_rr_onehot_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;

  logic       Clk;
  logic       Rst_n;
  logic       En;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Gnt;
  logic       GntValid;
  logic [1:0] GntIdx;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who holds the resource, for how long, and the last winner.
  bit         m_busy;
  int         m_holder;
  int         m_last;
  int         m_tenure;
  logic [3:0] exp_gnt;

  rr_onehot_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Req(Req), .Done(Done),
    .Gnt(Gnt), .GntValid(GntValid), .GntIdx(GntIdx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Structural invariant on every cycle, independent of the model.
  always @(negedge Clk) begin
    checks++;
    if (!$onehot0(Gnt) || (GntValid !== (|Gnt))) begin
      failures++;
      $display("FAIL invariant: Gnt=%b GntValid=%b required onehot0 and GntValid==|Gnt",
               Gnt, GntValid);
    end
  end

  task automatic model_reset();
    m_busy   = 1'b0;
    m_holder = 0;
    m_last   = N_REQ - 1;
    m_tenure = 0;
    exp_gnt  = 4'b0000;
  endtask

  task automatic model_step(input logic en, input logic [3:0] req, input logic done);
    if (m_busy) begin
      if (done || !req[m_holder] || !en || m_tenure == MAX_HOLD) m_busy = 1'b0;
      else if (m_tenure < MAX_HOLD) m_tenure++;
    end else if (en && req != 4'b0000) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!m_busy && req[(m_last + k) % N_REQ]) begin
          m_busy   = 1'b1;
          m_holder = (m_last + k) % N_REQ;
        end
      end
      m_last   = m_holder;
      m_tenure = 1;
    end
    exp_gnt = m_busy ? (4'b0001 << m_holder) : 4'b0000;
  endtask

  // Called at a negedge; drives inputs, crosses one rising edge, returns at the next negedge.
  task automatic tick(input logic en, input logic [3:0] req, input logic done);
    En = en; Req = req; Done = done;
    @(posedge Clk);
    model_step(en, req, done);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    En = 1'b0; Req = 4'b0000; Done = 1'b0;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    model_reset();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    apply_reset();
    checks++;
    if (Gnt !== 4'b0000 || GntValid !== 1'b0 || GntIdx !== 2'd0) begin
      failures++;
      $display("FAIL reset: Gnt=%b GntValid=%b GntIdx=%0d required 0000/0/0", Gnt, GntValid, GntIdx);
    end
  endtask

  task automatic test_first_grant();
    tick(1'b1, 4'b0001, 1'b0);
    checks++;
    if (Gnt !== 4'b0001 || GntValid !== 1'b1 || GntIdx !== 2'd0) begin
      failures++;
      $display("FAIL first_grant: Gnt=%b GntValid=%b GntIdx=%0d required 0001/1/0", Gnt, GntValid, GntIdx);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 4'b1111, 1'b0);
      checks++;
      if (Gnt !== seq[i] || Gnt !== exp_gnt) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: Gnt=%b required %b", i, Gnt, seq[i]);
      end
      tick(1'b1, 4'b1111, 1'b1);
      checks++;
      if (Gnt !== 4'b0000) begin
        failures++;
        $display("FAIL rotation_bubble[%0d]: Gnt=%b required 0000", i, Gnt);
      end
    end
  endtask

  task automatic test_max_hold();
    logic [3:0] want;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4'b0100, 1'b0);
      want = (i == 8) ? 4'b0000 : 4'b0100;
      checks++;
      if (Gnt !== want || Gnt !== exp_gnt) begin
        failures++;
        $display("FAIL max_hold[%0d]: Gnt=%b required %b", i, Gnt, want);
      end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    tick(1'b1, 4'b0010, 1'b0);
    checks++;
    if (Gnt !== 4'b0010) begin
      failures++;
      $display("FAIL enable_grant: Gnt=%b required 0010", Gnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'b1111, 1'b0);
      checks++;
      if (Gnt !== 4'b0000 || GntValid !== 1'b0) begin
        failures++;
        $display("FAIL enable_off[%0d]: Gnt=%b GntValid=%b required 0000/0", i, Gnt, GntValid);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick(1'b1, 4'b1000, 1'b0);
    tick(1'b1, 4'b1001, 1'b1);
    tick(1'b1, 4'b1001, 1'b0);
    checks++;
    if (Gnt !== 4'b0001 || GntIdx !== 2'd0) begin
      failures++;
      $display("FAIL wrap: Gnt=%b GntIdx=%0d required 0001/0", Gnt, GntIdx);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1'b1, 4'b0100, 1'b0);
    #1 Rst_n = 1'b0;
    #1;
    checks++;
    if (Gnt !== 4'b0000 || GntValid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: Gnt=%b GntValid=%b required 0000/0", Gnt, GntValid);
    end
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    tick(1'b1, 4'b1010, 1'b0);
    checks++;
    if (Gnt !== 4'b0010 || GntIdx !== 2'd1) begin
      failures++;
      $display("FAIL restart_after_reset: Gnt=%b GntIdx=%0d required 0010/1", Gnt, GntIdx);
    end
  endtask

  task automatic test_random();
    logic       en;
    logic [3:0] req;
    logic       done;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0);
      tick(en, req, done);
      checks++;
      if (Gnt !== exp_gnt || (m_busy && GntIdx !== 2'(m_holder))) begin
        failures++;
        $display("FAIL random[%0d]: Gnt=%b GntIdx=%0d required %b/%0d", i, Gnt, GntIdx, exp_gnt, m_holder);
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b0; Req = 4'b0000; Done = 1'b0;
    model_reset();
    test_reset();
    test_first_grant();
    test_rotation();
    test_max_hold();
    test_enable();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
